// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, field positions, write masks and exception codes
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_CU0    = 28;

    localparam int CA_EXC_LO   = 2;
    localparam int CA_IP_SW_LO = 8;
    localparam int CA_IP_HW_LO = 10;
    localparam int CA_TIMER_IP = 15;
    localparam int CA_WP       = 22;
    localparam int CA_IV       = 23;
    localparam int CA_BD       = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_SYS  = 5'd8,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] merge_masked(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_if.sv
// rtl/cp0_if.sv - MTC0 write / MFC0 read port bundle between pipeline and CP0
interface cp0_if #(
    parameter int DATA_W = 32
);
    logic              we_i;
    logic [4:0]        waddr_i;
    logic [DATA_W-1:0] data_i;
    logic [4:0]        raddr_i;
    logic [DATA_W-1:0] data_o;

    modport master (output we_i, waddr_i, data_i, raddr_i, input data_o);
    modport slave  (input we_i, waddr_i, data_i, raddr_i, output data_o);
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - prescaled Count, Compare and sticky timer interrupt
module cp0_timer #(
    parameter int DATA_W    = 32,
    parameter int TIMER_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we_i,
    input  logic              compare_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] count_o,
    output logic [DATA_W-1:0] compare_o,
    output logic              timer_int_o
);
    localparam logic [7:0] PRESC_MAX = 8'(TIMER_DIV - 1);

    logic [7:0]        presc_q, presc_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              timer_q, timer_d;

    always_comb begin
        presc_d   = presc_q + 8'd1;
        count_d   = count_q;
        compare_d = compare_q;
        timer_d   = timer_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_q + 1'b1;
        end
        // A software load restarts the prescale period as well
        if (count_we_i) begin
            presc_d = '0;
            count_d = wdata_i;
        end
        if ((compare_q != '0) && (count_q == compare_q))
            timer_d = 1'b1;
        if (compare_we_i) begin
            compare_d = wdata_i;
            timer_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor 0: Status/Cause/EPC, exception entry/ERET, read mux
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          N_HWINT    = 6,
    parameter int          TIMER_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic               clk,
    input  logic               rst,
    cp0_if.slave               bus,
    input  logic [N_HWINT-1:0] int_i,
    input  logic               excp_valid_i,
    input  logic [4:0]         excp_code_i,
    input  logic [DATA_W-1:0]  excp_pc_i,
    input  logic               excp_bd_i,
    input  logic               eret_i,
    output logic [DATA_W-1:0]  count_o,
    output logic [DATA_W-1:0]  compare_o,
    output logic [DATA_W-1:0]  status_o,
    output logic [DATA_W-1:0]  cause_o,
    output logic [DATA_W-1:0]  epc_o,
    output logic               timer_int_o,
    output logic               int_req_o
);
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);

    cp0_timer #(
        .DATA_W    (DATA_W),
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .wdata_i      (bus.data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] cause_q, cause_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [5:0]        ip_ext;

    always_comb begin
        ip_ext              = '0;
        ip_ext[N_HWINT-1:0] = int_i;
    end

    // Field priority: exception, then ERET, then MTC0; unrelated fields of an MTC0 still land
    always_comb begin
        status_d = status_q;
        if (wr_status)
            status_d = bus.data_i & STATUS_WMASK;
        if (excp_valid_i)
            status_d[ST_EXL] = 1'b1;
        else if (eret_i)
            status_d[ST_EXL] = 1'b0;

        cause_d = cause_q;
        cause_d[CA_IP_HW_LO +: 6] = ip_ext;
        if (wr_cause)
            cause_d = merge_masked(cause_d, bus.data_i, CAUSE_WMASK);
        if (excp_valid_i) begin
            cause_d[CA_EXC_LO +: 5] = excp_code_i;
            if (!status_q[ST_EXL])
                cause_d[CA_BD] = excp_bd_i;
        end

        epc_d = epc_q;
        if (excp_valid_i && !status_q[ST_EXL])
            epc_d = excp_bd_i ? excp_pc_i - 32'd4 : excp_pc_i;
        else if (wr_epc)
            epc_d = bus.data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        cause_o              = cause_q;
        cause_o[CA_TIMER_IP] = cause_q[CA_TIMER_IP] | timer_int_o;
    end

    assign status_o  = status_q;
    assign epc_o     = epc_q;
    assign int_req_o = (|(status_q[ST_IM_LO +: 8] & cause_o[CA_IP_SW_LO +: 8]))
                       & status_q[ST_IE] & ~status_q[ST_EXL];

    logic [DATA_W-1:0] rdata;

    always_comb begin
        rdata = '0;
        unique case (bus.raddr_i)
            REG_COUNT:   rdata = count_o;
            REG_COMPARE: rdata = compare_o;
            REG_STATUS:  rdata = status_o;
            REG_CAUSE:   rdata = cause_o;
            REG_EPC:     rdata = epc_o;
            REG_PRID:    rdata = PRID_VAL;
            REG_CONFIG:  rdata = CONFIG_VAL;
            default:     rdata = '0;
        endcase
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            unique case (bus.raddr_i)
                REG_COUNT, REG_COMPARE, REG_EPC: rdata = bus.data_i;
                REG_STATUS: rdata = bus.data_i & STATUS_WMASK;
                REG_CAUSE:  rdata = merge_masked(cause_o, bus.data_i, CAUSE_WMASK);
                default:    ;
            endcase
        end
    end

    assign bus.data_o = rdata;

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit against a behavioural CP0 model
module tb_cp0_unit;
    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        excp_valid_i, excp_bd_i, eret_i;
    logic [4:0]  excp_code_i;
    logic [31:0] excp_pc_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o, int_req_o;

    cp0_if #(.DATA_W(32)) bus ();

    cp0_unit #(
        .DATA_W(32), .N_HWINT(6), .TIMER_DIV(TDIV),
        .PRID_VAL(32'h004C0102), .CONFIG_VAL(32'h00008000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .int_i(int_i),
        .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i),
        .excp_pc_i(excp_pc_i), .excp_bd_i(excp_bd_i), .eret_i(eret_i),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o),
        .timer_int_o(timer_int_o), .int_req_o(int_req_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: architectural fields kept separately
    bit [31:0] m_count, m_compare, m_status, m_epc;
    int        m_phase;
    bit        m_tint, m_bd, m_iv, m_wp;
    bit [1:0]  m_ipsw;
    bit [4:0]  m_exc;
    bit [5:0]  m_iphw;

    function automatic bit [31:0] exp_cause();
        return {m_bd, 7'b0, m_iv, m_wp, 6'b0, m_iphw[5] | m_tint, m_iphw[4:0],
                m_ipsw, 1'b0, m_exc, 2'b0};
    endfunction

    function automatic bit exp_int_req();
        bit [7:0] ip;
        bit [31:0] c;
        c  = exp_cause();
        ip = c[15:8];
        return (|(m_status[15:8] & ip)) && m_status[0] && !m_status[1];
    endfunction

    function automatic bit [31:0] exp_read(input bit [4:0] r);
        bit [31:0] c;
        if (bus.we_i && bus.waddr_i == r) begin
            case (r)
                5'd9, 5'd11, 5'd14: return bus.data_i;
                5'd12: return bus.data_i & 32'h1000_FF03;
                5'd13: begin
                    c = exp_cause();
                    c[23] = bus.data_i[23];
                    c[22] = bus.data_i[22];
                    c[9:8] = bus.data_i[9:8];
                    return c;
                end
                default: ;
            endcase
        end
        case (r)
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return exp_cause();
            5'd14: return m_epc;
            5'd15: return 32'h004C0102;
            5'd16: return 32'h00008000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        bit        wr9, wr11, wr12, wr13, wr14;
        bit [31:0] n_status;
        if (rst) begin
            m_count = 0; m_compare = 0; m_status = 0; m_epc = 0; m_phase = 0;
            m_tint = 0; m_bd = 0; m_iv = 0; m_wp = 0; m_ipsw = 0; m_exc = 0; m_iphw = 0;
            return;
        end
        wr9  = bus.we_i && bus.waddr_i == 5'd9;
        wr11 = bus.we_i && bus.waddr_i == 5'd11;
        wr12 = bus.we_i && bus.waddr_i == 5'd12;
        wr13 = bus.we_i && bus.waddr_i == 5'd13;
        wr14 = bus.we_i && bus.waddr_i == 5'd14;

        if (wr11) m_tint = 0;
        else if (m_compare != 0 && m_count == m_compare) m_tint = 1;

        if (excp_valid_i && !m_status[1]) m_epc = excp_bd_i ? excp_pc_i - 32'd4 : excp_pc_i;
        else if (wr14) m_epc = bus.data_i;
        if (excp_valid_i) begin
            if (!m_status[1]) m_bd = excp_bd_i;
            m_exc = excp_code_i;
        end

        n_status = wr12 ? (bus.data_i & 32'h1000_FF03) : m_status;
        if (excp_valid_i) n_status[1] = 1;
        else if (eret_i) n_status[1] = 0;
        m_status = n_status;

        if (wr9) begin
            m_count = bus.data_i;
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % TDIV;
            if (m_phase == 0) m_count = m_count + 1;
        end
        if (wr11) m_compare = bus.data_i;
        if (wr13) begin
            m_iv = bus.data_i[23]; m_wp = bus.data_i[22]; m_ipsw = bus.data_i[9:8];
        end
        m_iphw = int_i;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we_i = 0; bus.waddr_i = 0; bus.data_i = 0;
        excp_valid_i = 0; excp_code_i = 0; excp_pc_i = 0; excp_bd_i = 0; eret_i = 0;
    endtask

    task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
        idle();
        bus.we_i = 1; bus.waddr_i = a; bus.data_i = d;
    endtask

    task automatic do_reset();
        rst = 1;
        mtc0(5'd12, 32'hFFFF_FFFF);
        excp_valid_i = 1; eret_i = 0; excp_pc_i = 32'h40; excp_code_i = 5'd8;
        int_i = 6'h3F;
        step();
        rst = 0;
        int_i = 0;
        idle();
    endtask

    task automatic test_reset();
        bit [31:0] want;
        do_reset();
        for (int r = 9; r <= 16; r++) begin
            bus.raddr_i = 5'(r);
            #1;
            case (r)
                15: want = 32'h004C0102;
                16: want = 32'h00008000;
                default: want = 32'h0;
            endcase
            n_checks++;
            if (bus.data_o !== want || bus.data_o !== exp_read(5'(r))) begin
                n_fail++;
                $display("FAIL reset_read r%0d got %h want %h", r, bus.data_o, want);
            end
        end
        n_checks++;
        if (timer_int_o !== 1'b0 || int_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got tint=%b req=%b want 0 0", timer_int_o, int_req_o);
        end
    endtask

    task automatic test_timer();
        int rise = -1;
        do_reset();
        mtc0(5'd11, 32'd3);
        for (int e = 1; e <= 20; e++) begin
            step();
            idle();
            if (timer_int_o === 1'b1 && rise < 0) rise = e;
            n_checks++;
            if (timer_int_o !== m_tint || count_o !== m_count) begin
                n_fail++;
                $display("FAIL timer_track e%0d got tint=%b cnt=%h want %b %h",
                         e, timer_int_o, count_o, m_tint, m_count);
            end
        end
        n_checks++;
        if (rise != 13) begin
            n_fail++;
            $display("FAIL timer_rise got %0d want 13", rise);
        end
        mtc0(5'd11, 32'd0);
        step();
        idle();
        n_checks++;
        if (timer_int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_clear got %b want 0", timer_int_o);
        end
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (count_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL count_hold got %h want ffffffff", count_o);
        end
        step();
        n_checks++;
        if (count_o !== 32'h0 || count_o !== m_count) begin
            n_fail++;
            $display("FAIL count_wrap got %h want 0", count_o);
        end
    endtask

    task automatic test_int();
        mtc0(5'd12, 32'h0000_FF01);
        int_i = 6'b000001;
        step();
        idle();
        n_checks++;
        if (cause_o[10] !== 1'b1 || int_req_o !== 1'b1 || int_req_o !== exp_int_req()) begin
            n_fail++;
            $display("FAIL int_req got ip10=%b req=%b want 1 1", cause_o[10], int_req_o);
        end
        mtc0(5'd12, 32'h0000_FF03);
        step();
        idle();
        n_checks++;
        if (int_req_o !== 1'b0 || status_o !== 32'h0000_FF03) begin
            n_fail++;
            $display("FAIL int_exl got req=%b st=%h want 0 0000ff03", int_req_o, status_o);
        end
        int_i = 0;
    endtask

    task automatic test_exception();
        mtc0(5'd12, 32'h0);
        step();
        idle();
        excp_valid_i = 1; excp_pc_i = 32'h100; excp_bd_i = 1; excp_code_i = 5'd12;
        step();
        idle();
        n_checks++;
        if (epc_o !== 32'hFC || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd12 || status_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL excp_entry got epc=%h cause=%h st=%h want epc fc bd 1 exc 12 exl 1",
                     epc_o, cause_o, status_o);
        end
        excp_valid_i = 1; excp_pc_i = 32'h200; excp_bd_i = 0; excp_code_i = 5'd4;
        step();
        idle();
        n_checks++;
        if (epc_o !== 32'hFC || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4) begin
            n_fail++;
            $display("FAIL excp_nested got epc=%h cause=%h want epc fc bd 1 exc 4", epc_o, cause_o);
        end
        eret_i = 1;
        step();
        idle();
        n_checks++;
        if (status_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL eret got exl=%b want 0", status_o[1]);
        end
    endtask

    task automatic test_priority();
        mtc0(5'd12, 32'h0000_0001);
        step();
        mtc0(5'd12, 32'h0);
        excp_valid_i = 1; excp_pc_i = 32'h300; excp_code_i = 5'd8;
        step();
        idle();
        n_checks++;
        if (status_o[1] !== 1'b1 || status_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_status got st=%h want exl 1 ie 0", status_o);
        end
        mtc0(5'd9, 32'h20);
        step();
        mtc0(5'd11, 32'h20);
        step();
        mtc0(5'd11, 32'h20);
        step();
        idle();
        n_checks++;
        if (timer_int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_compare got tint=%b want 0", timer_int_o);
        end
        step();
        n_checks++;
        if (timer_int_o !== 1'b1 || timer_int_o !== m_tint) begin
            n_fail++;
            $display("FAIL match_after got tint=%b want 1", timer_int_o);
        end
    endtask

    task automatic test_bypass();
        bit [31:0] c0;
        mtc0(5'd9, 32'h55);
        bus.raddr_i = 5'd9;
        #1;
        n_checks++;
        if (bus.data_o !== 32'h55) begin
            n_fail++;
            $display("FAIL bypass_count got %h want 00000055", bus.data_o);
        end
        step();
        idle();
        c0 = cause_o;
        mtc0(5'd13, 32'hFFFF_FFFF);
        bus.raddr_i = 5'd13;
        #1;
        n_checks++;
        if (bus.data_o !== (c0 | 32'h00C0_0300)) begin
            n_fail++;
            $display("FAIL bypass_cause got %h want %h", bus.data_o, c0 | 32'h00C0_0300);
        end
        step();
        idle();
        n_checks++;
        if (cause_o !== (c0 | 32'h00C0_0300) || cause_o !== exp_cause()) begin
            n_fail++;
            $display("FAIL cause_mask got %h want %h", cause_o, c0 | 32'h00C0_0300);
        end
        mtc0(5'd15, 32'h1234_5678);
        bus.raddr_i = 5'd15;
        #1;
        n_checks++;
        if (bus.data_o !== 32'h004C0102) begin
            n_fail++;
            $display("FAIL prid_ro got %h want 004c0102", bus.data_o);
        end
        step();
        idle();
    endtask

    task automatic test_random();
        bit [4:0] addrs [9] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd10, 5'd0};
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(0, 2) == 0) begin
                bus.we_i    = 1;
                bus.waddr_i = addrs[$urandom_range(0, 8)];
                bus.data_i  = ($urandom_range(0, 2) == 0) ? m_count + 32'($urandom_range(0, 3)) : $urandom;
            end
            if ($urandom_range(0, 9) == 0) begin
                excp_valid_i = 1; excp_pc_i = $urandom; excp_bd_i = 1'($urandom);
                excp_code_i = 5'($urandom);
            end
            if ($urandom_range(0, 9) == 0) eret_i = 1;
            if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            bus.raddr_i = 5'($urandom_range(0, 20));
            #1;
            n_checks++;
            if (bus.data_o !== exp_read(bus.raddr_i) || count_o !== m_count || compare_o !== m_compare
                || status_o !== m_status || cause_o !== exp_cause() || epc_o !== m_epc
                || timer_int_o !== m_tint || int_req_o !== exp_int_req()) begin
                n_fail++;
                $display("FAIL random i%0d got rd=%h cnt=%h cmp=%h st=%h ca=%h epc=%h t=%b q=%b want rd=%h cnt=%h cmp=%h st=%h ca=%h epc=%h t=%b q=%b",
                         i, bus.data_o, count_o, compare_o, status_o, cause_o, epc_o, timer_int_o, int_req_o,
                         exp_read(bus.raddr_i), m_count, m_compare, m_status, exp_cause(), m_epc, m_tint, exp_int_req());
            end
            step();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1;
        int_i = 0;
        bus.raddr_i = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_timer();
        test_int();
        test_exception();
        test_priority();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
